pipelined_carry_adder: RTL and testbench

//  Parametrised, pipelined successor to the 4-bit ripple-carry increment circuit.

---
 rtl/pipelined_carry_adder.sv | 170 +++++++++++++++++
 tb/tb_pipelined_carry_adder.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_adder.sv
// ---------------------------------------------------------------------------
// pipelined_carry_adder
//
// Pipelined ripple-carry adder / incrementer. Each pipeline stage adds one
// SEG-bit segment of the operands plus the carry from the previous stage.
// The carry is registered between stages. Operand segments that have not yet
// been consumed travel down the pipe alongside the data (skew). Sum segments
// that are already finished also travel down the pipe (deskew), so every bit
// of S leaves the last stage in the same cycle.
//
// Parameters
//   WIDTH   operand / sum width (must be a multiple of SEG)
//   SEG     bits added per stage
//   STAGES  WIDTH/SEG, derived; equals the pipeline latency in cycles
//
// Ports
//   clk        in   1      clock, all state on the rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      operands accepted this cycle
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B (treated as 0 when INC=1)
//   Ci         in   1      carry-in
//   INC        in   1      1: S = A + Ci, 0: S = A + B + Ci
//   out_valid  out  1      S / Co (/ OVF) valid
//   out_ready  in   1      downstream accepts the result
//   S          out  WIDTH  sum, modulo 2^WIDTH
//   Co         out  1      carry out of bit WIDTH-1
//   OVF        out  1      signed overflow of S (only with ADDER_OVF_EN)
//
// Optional feature macro: ADDER_OVF_EN adds the OVF output and its pipeline
// register. Without it there is no OVF port and no overflow logic.
// ---------------------------------------------------------------------------
module pipelined_carry_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             INC,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co
`ifdef ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int STAGES = WIDTH / SEG;

  generate
    if (WIDTH % SEG != 0) begin : g_bad_cfg
      $error("pipelined_carry_adder: WIDTH must be a multiple of SEG");
    end
  endgenerate

  // Inter-stage buses. Index k is the input of stage k; index STAGES is the
  // output of the last stage, which is also the block's output register.
  // wordIn holds finished sum bits below the current segment and untouched
  // A bits from the current segment upward.
  logic [WIDTH-1:0] wordIn  [STAGES+1];
  logic             carryIn [STAGES+1];
  logic             validIn [STAGES+1];
  // Remaining B' bits, shifted so the segment for stage k sits at bit 0.
  logic [WIDTH-1:0] bIn     [STAGES];
  logic             adv;

  // Single global advance: the whole pipe moves when the output register is
  // empty or being drained, otherwise every stage holds.
  assign adv      = !validIn[STAGES] | out_ready;
  assign in_ready = adv;

  assign wordIn[0]  = A;
  assign carryIn[0] = Ci;
  assign validIn[0] = in_valid;
  // INC is folded in here, so it travels with its own transaction only.
  assign bIn[0]     = INC ? '0 : B;

  assign S         = wordIn[STAGES];
  assign Co        = carryIn[STAGES];
  assign out_valid = validIn[STAGES];

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] word_q;
      logic [WIDTH-1:0] word_d;
      logic             carry_q;
      logic             carry_d;
      logic             valid_q;
      logic [SEG-1:0]   segSum;

      // Ripple-add this stage's segment and splice the result into the
      // word in place of the A segment it consumed.
      always_comb begin
        {carry_d, segSum} = {1'b0, wordIn[k][k*SEG +: SEG]}
                          + {1'b0, bIn[k][SEG-1:0]}
                          + {{SEG{1'b0}}, carryIn[k]};
        word_d = wordIn[k];
        word_d[k*SEG +: SEG] = segSum;
      end

      // Stage register: cleared on reset, loaded on advance, held on stall.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          word_q  <= '0;
          carry_q <= 1'b0;
          valid_q <= 1'b0;
        end else if (adv) begin
          word_q  <= word_d;
          carry_q <= carry_d;
          valid_q <= validIn[k];
        end
      end

      assign wordIn[k+1]  = word_q;
      assign carryIn[k+1] = carry_q;
      assign validIn[k+1] = valid_q;

      // B' skew register: only stages that still have a later stage to feed
      // need to carry the unconsumed upper B' bits forward.
      if (k < STAGES - 1) begin : g_skew
        logic [WIDTH-1:0] bSkew_q;

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            bSkew_q <= '0;
          end else if (adv) begin
            bSkew_q <= bIn[k] >> SEG;
          end
        end

        assign bIn[k+1] = bSkew_q;
      end

`ifdef ADDER_OVF_EN
      // The last stage still sees the original A and B' sign bits, so the
      // signed overflow flag is formed here next to the top sum bit.
      if (k == STAGES - 1) begin : g_ovf
        logic ovf_q;
        logic ovf_d;

        always_comb begin
          ovf_d = (wordIn[k][WIDTH-1] == bIn[k][SEG-1])
                & (segSum[SEG-1] != wordIn[k][WIDTH-1]);
        end

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            ovf_q <= 1'b0;
          end else if (adv) begin
            ovf_q <= ovf_d;
          end
        end

        assign OVF = ovf_q;
      end
`else
      // Overflow flag not built in this configuration.
`endif
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_carry_adder
//
// Drives a 16-bit / 4-bit-segment adder and an 8-bit single-stage adder.
// Expected results come from plain integer arithmetic in refAdd and are
// queued at input transfer, then popped at output transfer.
// ---------------------------------------------------------------------------
module tb_pipelined_carry_adder;

  localparam int LAT16 = 4;
  localparam int LAT8  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] A, B, S;
  logic        Ci, INC, Co;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  A8, B8, S8;
  logic        Ci8, INC8, Co8;

`ifdef ADDER_OVF_EN
  logic        ovf16, ovf8;
`endif

  int checks = 0;
  int errors = 0;

  // {ovf, co, sum[15:0]}
  logic [17:0] expQ [$];

  pipelined_carry_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Ci(Ci), .INC(INC),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Co(Co)
`ifdef ADDER_OVF_EN
    , .OVF(ovf16)
`endif
  );

  pipelined_carry_adder #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A8), .B(B8), .Ci(Ci8), .INC(INC8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .S(S8), .Co(Co8)
`ifdef ADDER_OVF_EN
    , .OVF(ovf8)
`endif
  );

  // Reference: true sum of A + B' + Ci, its carry beyond WIDTH bits, and
  // signed overflow judged on the mathematical signed result.
  function automatic logic [17:0] refAdd(input int width, input logic [15:0] a,
                                         input logic [15:0] b, input logic ci,
                                         input logic inc);
    longint modv, half, bEff, total, sa, sb, ss;
    logic [17:0] r;
    modv  = longint'(1) << width;
    half  = modv / 2;
    bEff  = inc ? 0 : longint'(b);
    total = longint'(a) + bEff + longint'(ci);
    sa    = (longint'(a) >= half) ? longint'(a) - modv : longint'(a);
    sb    = (bEff >= half) ? bEff - modv : bEff;
    ss    = sa + sb + longint'(ci);
    r       = '0;
    r[17]   = (ss >= half) || (ss < -half);
    r[16]   = (total >= modv);
    r[15:0] = 16'(total % modv);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom); Ci = 1'b1; INC = 1'b0;
    out_ready = 1'b1;
    in_valid8 = 1'b1; A8 = 8'($urandom); B8 = 8'($urandom); Ci8 = 1'b1; INC8 = 1'b0;
    out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (S !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_S got=%h want=0000", S);
    end
    checks++;
    if (Co !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_Co got=%b want=0", Co);
    end
    checks++;
    if (out_valid8 !== 1'b0 || S8 !== 8'h00 || Co8 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_w8 got v=%b S=%h Co=%b want 0/00/0", out_valid8, S8, Co8);
    end
`ifdef ADDER_OVF_EN
    checks++;
    if (ovf16 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_OVF got=%b want=0", ovf16);
    end
`endif
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_valid8 = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready got=%b/%b want=1/1", in_ready, in_ready8);
    end
    for (int i = 0; i < LAT16 + 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_no_ghost cycle=%0d got=%b want=0", i, out_valid);
      end
    end
  endtask

  task automatic test_inc_carry();
    int lat;
    @(posedge clk); #1;
    A = 16'hFFFF; B = 16'($urandom) | 16'h0001; Ci = 1'b1; INC = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != LAT16) begin
      errors++; $display("[TB] FAIL inc_latency got=%0d want=%0d", lat, LAT16);
    end
    checks++;
    if (S !== 16'h0000 || Co !== 1'b1) begin
      errors++; $display("[TB] FAIL inc_carry got S=%h Co=%b want S=0000 Co=1", S, Co);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int lat;
    @(posedge clk); #1;
    A = 16'h7FFF; B = 16'h0001; Ci = 1'b0; INC = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != LAT16) begin
      errors++; $display("[TB] FAIL ovf_latency got=%0d want=%0d", lat, LAT16);
    end
    checks++;
    if (S !== 16'h8000 || Co !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_sum got S=%h Co=%b want S=8000 Co=0", S, Co);
    end
`ifdef ADDER_OVF_EN
    checks++;
    if (ovf16 !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf_flag got=%b want=1", ovf16);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    int sent, got, firstCyc, lastCyc;
    logic [17:0] e;
    @(posedge clk); #1;
    expQ.delete();
    sent = 0; got = 0; firstCyc = -1; lastCyc = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 100; cyc++) begin
      if (sent < 100) begin
        in_valid = 1'b1;
        A = 16'($urandom); B = 16'($urandom); Ci = 1'($urandom); INC = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL stream_unexpected cycle=%0d S=%h want no output", cyc, S);
        end else begin
          e = expQ.pop_front();
          if ({Co, S} !== e[16:0]) begin
            errors++; $display("[TB] FAIL stream_data idx=%0d got=%h want=%h", got, {Co, S}, e[16:0]);
          end
`ifdef ADDER_OVF_EN
          checks++;
          if (ovf16 !== e[17]) begin
            errors++; $display("[TB] FAIL stream_ovf idx=%0d got=%b want=%b", got, ovf16, e[17]);
          end
`endif
          got++;
          if (firstCyc < 0) firstCyc = cyc;
          lastCyc = cyc;
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        expQ.push_back(refAdd(16, A, B, Ci, INC));
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 100) begin
      errors++; $display("[TB] FAIL stream_count got=%0d want=100", got);
    end
    checks++;
    if (firstCyc != LAT16) begin
      errors++; $display("[TB] FAIL stream_first_latency got=%0d want=%0d", firstCyc, LAT16);
    end
    checks++;
    if (lastCyc - firstCyc != 99) begin
      errors++; $display("[TB] FAIL stream_throughput span got=%0d want=99", lastCyc - firstCyc);
    end
  endtask

  task automatic test_backpressure();
    int sent, got, stallCnt;
    logic accepted;
    logic [16:0] prevOut;
    logic [17:0] e;
    @(posedge clk); #1;
    expQ.delete();
    sent = 0; got = 0; stallCnt = 0; accepted = 1'b1; prevOut = '0;
    for (int cyc = 0; cyc < 400 && got < 24; cyc++) begin
      if (sent < 24) begin
        in_valid = 1'b1;
        if (accepted) begin
          A = 16'($urandom); B = 16'($urandom); Ci = 1'($urandom); INC = 1'($urandom);
        end
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (stallCnt >= 5) ? ($urandom_range(0, 3) != 0) : 1'b0;
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL bp_unexpected cycle=%0d S=%h want no output", cyc, S);
        end else begin
          e = expQ[0];
          if ({Co, S} !== e[16:0]) begin
            errors++; $display("[TB] FAIL bp_data idx=%0d got=%h want=%h", got, {Co, S}, e[16:0]);
          end
          if (out_ready) begin
            void'(expQ.pop_front());
            got++;
          end
        end
        if (stallCnt < 5) begin
          checks++;
          if (in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_in_ready stall=%0d got=%b want=0", stallCnt, in_ready);
          end
          if (stallCnt > 0) begin
            checks++;
            if ({Co, S} !== prevOut) begin
              errors++; $display("[TB] FAIL bp_stable stall=%0d got=%h want=%h", stallCnt, {Co, S}, prevOut);
            end
          end
          prevOut = {Co, S};
          stallCnt++;
        end
      end
      accepted = 1'b0;
      if (in_valid && in_ready === 1'b1) begin
        expQ.push_back(refAdd(16, A, B, Ci, INC));
        sent++;
        accepted = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 24 || sent != 24 || expQ.size() != 0) begin
      errors++; $display("[TB] FAIL bp_count got=%0d sent=%0d left=%0d want 24/24/0", got, sent, expQ.size());
    end
    checks++;
    if (stallCnt != 5) begin
      errors++; $display("[TB] FAIL bp_stall_seen got=%0d want=5", stallCnt);
    end
  endtask

  task automatic test_reset_midflight();
    int lat;
    logic [17:0] e;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      A = 16'($urandom); B = 16'($urandom); Ci = 1'($urandom); INC = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL midflight_early i=%0d got=%b want=0", i, out_valid);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL midflight_dropped cycle=%0d got=%b want=0", i, out_valid);
      end
    end
    @(posedge clk); #1;
    A = 16'($urandom); B = 16'($urandom); Ci = 1'($urandom); INC = 1'($urandom);
    e = refAdd(16, A, B, Ci, INC);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != LAT16) begin
      errors++; $display("[TB] FAIL midflight_latency got=%0d want=%0d", lat, LAT16);
    end
    checks++;
    if ({Co, S} !== e[16:0]) begin
      errors++; $display("[TB] FAIL midflight_data got=%h want=%h", {Co, S}, e[16:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_inc_carry_w8();
    int lat;
    @(posedge clk); #1;
    A8 = 8'hFF; B8 = 8'($urandom) | 8'h01; Ci8 = 1'b1; INC8 = 1'b1;
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (out_valid8 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != LAT8) begin
      errors++; $display("[TB] FAIL w8_inc_latency got=%0d want=%0d", lat, LAT8);
    end
    checks++;
    if (S8 !== 8'h00 || Co8 !== 1'b1) begin
      errors++; $display("[TB] FAIL w8_inc_carry got S=%h Co=%b want S=00 Co=1", S8, Co8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream_w8();
    int sent, got, firstCyc, lastCyc;
    logic [17:0] e;
    @(posedge clk); #1;
    expQ.delete();
    sent = 0; got = 0; firstCyc = -1; lastCyc = -1;
    out_ready8 = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 100; cyc++) begin
      if (sent < 100) begin
        in_valid8 = 1'b1;
        A8 = 8'($urandom); B8 = 8'($urandom); Ci8 = 1'($urandom); INC8 = 1'($urandom);
      end else begin
        in_valid8 = 1'b0;
      end
      @(negedge clk);
      if (out_valid8 === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL w8_stream_unexpected cycle=%0d S=%h want no output", cyc, S8);
        end else begin
          e = expQ.pop_front();
          if ({Co8, S8} !== {e[16], e[7:0]}) begin
            errors++; $display("[TB] FAIL w8_stream_data idx=%0d got=%h want=%h", got, {Co8, S8}, {e[16], e[7:0]});
          end
`ifdef ADDER_OVF_EN
          checks++;
          if (ovf8 !== e[17]) begin
            errors++; $display("[TB] FAIL w8_stream_ovf idx=%0d got=%b want=%b", got, ovf8, e[17]);
          end
`endif
          got++;
          if (firstCyc < 0) firstCyc = cyc;
          lastCyc = cyc;
        end
      end
      if (in_valid8 && in_ready8 === 1'b1) begin
        expQ.push_back(refAdd(8, {8'h00, A8}, {8'h00, B8}, Ci8, INC8));
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    checks++;
    if (got != 100) begin
      errors++; $display("[TB] FAIL w8_stream_count got=%0d want=100", got);
    end
    checks++;
    if (firstCyc != LAT8) begin
      errors++; $display("[TB] FAIL w8_stream_first_latency got=%0d want=%0d", firstCyc, LAT8);
    end
    checks++;
    if (lastCyc - firstCyc != 99) begin
      errors++; $display("[TB] FAIL w8_stream_throughput span got=%0d want=99", lastCyc - firstCyc);
    end
  endtask

  // Scenario sequence; each task aligns itself to the clock before driving.
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; A = '0; B = '0; Ci = 1'b0; INC = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; A8 = '0; B8 = '0; Ci8 = 1'b0; INC8 = 1'b0; out_ready8 = 1'b1;
    test_reset();
    test_inc_carry();
    test_overflow();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    test_inc_carry_w8();
    test_stream_w8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
